// File: rtl/cache_axi_pkg.sv
// Shared types and constants for the cache-to-AXI4-Lite read bridge.
package cache_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    WAIT,
    RESP
  } bridge_state;

  localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
  localparam logic [31:0] TIMEOUT_DATA  = 32'hDEADBEEF;

endpackage

// File: rtl/cache_axi_rd_bridge_if.sv
// Cache miss request/response plus AXI4-Lite read channels.
// slave: the bridge side; master: the cache/memory environment side.
interface cache_axi_rd_bridge_if #(
  parameter int W = 32
);

  logic         axi_start_i;
  logic [W-1:0] axi_address_i;
  logic         axi_rdy_o;
  logic [W-1:0] axi_data_o;
  logic [W-1:0] m_araddr_o;
  logic         m_arvalid_o;
  logic         m_arready_i;
  logic [W-1:0] m_rdata_i;
  logic [1:0]   m_rresp_i;
  logic         m_rvalid_i;
  logic         m_rready_o;

  modport slave (
    input  axi_start_i,
    input  axi_address_i,
    output axi_rdy_o,
    output axi_data_o,
    output m_araddr_o,
    output m_arvalid_o,
    input  m_arready_i,
    input  m_rdata_i,
    input  m_rresp_i,
    input  m_rvalid_i,
    output m_rready_o
  );

  modport master (
    output axi_start_i,
    output axi_address_i,
    input  axi_rdy_o,
    input  axi_data_o,
    input  m_araddr_o,
    input  m_arvalid_o,
    output m_arready_i,
    output m_rdata_i,
    output m_rresp_i,
    output m_rvalid_i,
    input  m_rready_o
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter. clear restarts it; clear together with
// enable counts the clearing cycle itself, so the value becomes 1.
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] count_o,
  output logic             at_max_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;

  assign count_o  = count_q;
  assign at_max_o = (count_q >= MAX_V);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = enable_i ? WIDTH'(1) : '0;
    end else if (enable_i && !at_max_o) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/cache_axi_rd_bridge.sv
// One cache miss -> one AXI4-Lite read, answered with a one-cycle rdy.
// Optional CACHE_AXI_TIMEOUT_EN adds a request timeout and sticky err_o.
module cache_axi_rd_bridge
  import cache_axi_pkg::*;
#(
  parameter int total_width = 32,
  parameter int MIN_LAT     = 3
`ifdef CACHE_AXI_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input logic                  clk_i,
  input logic                  rst_i,
  cache_axi_rd_bridge_if.slave bus
`ifdef CACHE_AXI_TIMEOUT_EN
  , output logic               err_o
`endif
);

  localparam int LAT_W = (MIN_LAT < 1) ? 1 : $clog2(MIN_LAT + 1);

  bridge_state state_q, state_d;

  logic [total_width-1:0] addr_q, addr_d;
  logic [total_width-1:0] data_q, data_d;

  logic             start_acc;
  logic             lat_done;
  logic [LAT_W-1:0] lat_cnt;

  assign start_acc = (state_q == IDLE) && bus.axi_start_i;

  // Value n in the n-th cycle after start, so WAIT can leave at n = MIN_LAT
  sat_counter #(
    .WIDTH (LAT_W),
    .MAX   (MIN_LAT)
  ) u_lat (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (start_acc),
    .enable_i (1'b1),
    .count_o  (lat_cnt),
    .at_max_o (lat_done)
  );

`ifdef CACHE_AXI_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic            err_q, err_d;
  logic            to_exp;
  logic [TO_W-1:0] to_cnt;

  sat_counter #(
    .WIDTH (TO_W),
    .MAX   (TIMEOUT_CYCLES - 1)
  ) u_to (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (start_acc),
    .enable_i (1'b1),
    .count_o  (to_cnt),
    .at_max_o (to_exp)
  );

  assign err_o = err_q;

  logic unused_sig;
  assign unused_sig = ^{lat_cnt, to_cnt};
`else
  logic unused_sig;
  assign unused_sig = ^{lat_cnt, bus.m_rresp_i,
                        AXI_RESP_OKAY, TIMEOUT_DATA};
`endif

  assign bus.m_arvalid_o = (state_q == AR);
  assign bus.m_rready_o  = (state_q == R);
  assign bus.axi_rdy_o   = (state_q == RESP);
  assign bus.m_araddr_o  = addr_q;
  assign bus.axi_data_o  = data_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef CACHE_AXI_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.axi_start_i) begin
          addr_d  = bus.axi_address_i;
          state_d = AR;
        end
      end
      AR: begin
        if (bus.m_arready_i) begin
          state_d = R;
        end
`ifdef CACHE_AXI_TIMEOUT_EN
        else if (to_exp) begin
          data_d  = total_width'(TIMEOUT_DATA);
          err_d   = 1'b1;
          state_d = WAIT;
        end
`endif
      end
      R: begin
        if (bus.m_rvalid_i) begin
          data_d  = bus.m_rdata_i;
          state_d = WAIT;
`ifdef CACHE_AXI_TIMEOUT_EN
          if (bus.m_rresp_i != AXI_RESP_OKAY) err_d = 1'b1;
        end else if (to_exp) begin
          data_d  = total_width'(TIMEOUT_DATA);
          err_d   = 1'b1;
          state_d = WAIT;
`endif
        end
      end
      WAIT: begin
        if (lat_done) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

`ifdef CACHE_AXI_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end
`endif

endmodule
